// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port data memory.
// Latency: request sampled at edge N, one-cycle ack pulse in the cycle after edge N+1; one transaction per 3 cycles.
// Backpressure: a master holds req and its fields until ack; other requests wait in IDLE, lost if dropped before grant.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic                m0_ack_q, m0_ack_d;
  logic                m1_ack_q, m1_ack_d;
  logic                m0_err_q, m0_err_d;
  logic                m1_err_q, m1_err_d;
  logic                busy_q, busy_d;

  logic                pick;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_err;
  logic [DATA_W-1:0]   rd_result;

  // On a tie the master that was not served last wins.
  assign pick      = (m0_req & m1_req) ? ~last_q : m1_req;
  assign sel_we    = pick ? m1_we    : m0_we;
  assign sel_addr  = pick ? m1_addr  : m0_addr;
  assign sel_wdata = pick ? m1_wdata : m0_wdata;
  assign sel_err   = (sel_addr[ADDR_W-1 -: 4] == 4'h4) | (sel_addr[1:0] != 2'b00);
  assign rd_result = (~we_q & ~err_q) ? mem_rdata : '0;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    last_d     = last_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    mem_rd_d   = 1'b0;
    mem_wr_d   = 1'b0;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_err_d   = 1'b0;
    m1_err_d   = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          gnt_d    = pick;
          we_d     = sel_we;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          err_d    = sel_err;
          mem_rd_d = ~sel_we & ~sel_err;
          mem_wr_d = sel_we & ~sel_err;
          busy_d   = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (gnt_q) m1_rdata_d = rd_result;
        else       m0_rdata_d = rd_result;
        last_d   = gnt_q;
        m0_ack_d = ~gnt_q;
        m1_ack_d = gnt_q;
        m0_err_d = ~gnt_q & err_q;
        m1_err_d = gnt_q & err_q;
        state_d  = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      last_q     <= 1'b1;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      last_q     <= last_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
      busy_q     <= busy_d;
    end
  end

  // Address and data stay on the latches outside ACCESS; only the strobes qualify them.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, scoreboard of expected completions in grant order.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_rd, mem_wr, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_rd ? mem[mem_addr[7:2]] : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Expected outcome of a transaction, computed from the shadow memory in grant order.
  task automatic push_exp(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.m     = m;
    e.we    = we;
    e.addr  = a;
    e.wdata = d;
    e.err   = (a[31:28] == 4'h4) || (a[1:0] != 2'b00);
    e.rdata = (we || e.err) ? 32'h0 : ref_mem[a[7:2]];
    if (we && !e.err) ref_mem[a[7:2]] = d;
    sb.push_back(e);
  endtask

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
    end
  endtask

  task automatic do_txn(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
    int t;
    push_exp(m, we, a, d);
    @(negedge clk);
    drive(m, 1'b1, we, a, d);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!((m == 0) ? m0_ack : m1_ack) && t < 20);
    chk("latency", t, 2);
    drive(m, 1'b0, we, a, d);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ctl", {25'b0, m0_ack, m0_err, m1_ack, m1_err, mem_rd, mem_wr, busy}, 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
  endtask

  // Strobe and completion monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_wr) wr_cnt <= wr_cnt + 1;
      if (mem_rd) rd_cnt <= rd_cnt + 1;
      if (mem_rd || mem_wr) begin
        chk("strobe_expected", 32'(sb.size() != 0), 1);
        chk("strobe_both", {31'b0, mem_rd & mem_wr}, 0);
        if (sb.size() != 0) begin
          chk("strobe_on_err", {31'b0, sb[0].err}, 0);
          chk("strobe_we", {31'b0, mem_wr}, {31'b0, sb[0].we});
          chk("strobe_addr", mem_addr, sb[0].addr);
          if (mem_wr) chk("strobe_wdata", mem_wdata, sb[0].wdata);
        end
      end
      if (m0_ack || m1_ack) begin
        chk("ack_expected", 32'(sb.size() != 0), 1);
        chk("ack_both", {31'b0, m0_ack & m1_ack}, 0);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_master", m1_ack ? 1 : 0, e.m);
          chk("ack_err", {31'b0, m1_ack ? m1_err : m0_err}, {31'b0, e.err});
          chk("other_err", {31'b0, m1_ack ? m0_err : m1_err}, 0);
          chk("rdata", m1_ack ? m1_rdata : m0_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_t [4];
    int n, t, c0, w0, r0;
    exp_t ab;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'hA000_0000 + i;
      ref_mem[i] = 32'hA000_0000 + i;
    end
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    reset_n = 1'b1;
    @(negedge clk);

    // Simultaneous reads from reset: m0 first, then strict alternation.
    push_exp(0, 1'b0, 32'h10, 0);
    push_exp(1, 1'b0, 32'h20, 0);
    push_exp(0, 1'b0, 32'h10, 0);
    push_exp(1, 1'b0, 32'h20, 0);
    @(negedge clk);
    c0 = cyc;
    drive(0, 1'b1, 1'b0, 32'h10, 0);
    drive(1, 1'b1, 1'b0, 32'h20, 0);
    n = 0;
    t = 0;
    while (n < 4 && t < 40) begin
      @(negedge clk);
      t++;
      if (m0_ack || m1_ack) begin
        ack_t[n] = cyc;
        if (m0_ack && n == 2) m0_req = 1'b0;
        if (m1_ack && n == 3) m1_req = 1'b0;
        n++;
      end
    end
    chk("rr_ack_count", n, 4);
    chk("rr_first_lat", ack_t[0] - c0, 2);
    for (int i = 1; i < 4; i++) chk("rr_spacing", ack_t[i] - ack_t[i-1], 3);
    m0_req = 1'b0;
    m1_req = 1'b0;

    // Write then read back, one strobe cycle each.
    w0 = wr_cnt; r0 = rd_cnt;
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF);
    chk("wr_strobe_cycles", wr_cnt - w0, 1);
    do_txn(0, 1'b0, 32'h10, 0);
    chk("rd_strobe_cycles", rd_cnt - r0, 1);
    chk("rdback", m0_rdata, 32'hDEADBEEF);

    // Non-granted master's rdata holds.
    do_txn(1, 1'b1, 32'h30, 32'h12345678);
    do_txn(0, 1'b0, 32'h30, 0);
    do_txn(1, 1'b0, 32'h20, 0);
    chk("m0_rdata_hold", m0_rdata, 32'h12345678);
    chk("m1_rdata_upd", m1_rdata, 32'hA000_0008);

    // Rejected accesses: no strobes, err with ack, rdata cleared.
    w0 = wr_cnt; r0 = rd_cnt;
    do_txn(1, 1'b1, 32'h4000_0004, 32'hCAFEF00D);
    do_txn(1, 1'b1, 32'h0000_0006, 32'hCAFEF00D);
    chk("err_no_wr", wr_cnt - w0, 0);
    chk("err_no_rd", rd_cnt - r0, 0);
    chk("err_m1_rdata", m1_rdata, 32'h0);

    // m0 request raised and dropped while busy is never granted.
    push_exp(1, 1'b0, 32'h24, 0);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h24, 0);
    @(negedge clk);
    m1_req = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h10, 0);
    @(negedge clk);
    m0_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop_busy", {31'b0, busy}, 0);
    end
    chk("drop_sb_empty", sb.size(), 0);

    // Reset during ACCESS of a write aborts it.
    ab.m = 0; ab.we = 1'b1; ab.addr = 32'h18; ab.wdata = 32'h55AA55AA; ab.rdata = 0; ab.err = 1'b0;
    sb.push_back(ab);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h18, 32'h55AA55AA);
    @(negedge clk);
    chk("abort_wr_live", {31'b0, mem_wr}, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_strobes", {30'b0, mem_rd, mem_wr}, 0);
    m0_req = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_ack", {30'b0, m0_ack, m1_ack}, 0);
    do_txn(0, 1'b0, 32'h18, 0);
    chk("abort_not_written", m0_rdata, 32'hA000_0006);

    repeat (2) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter in front of the single-port data memory.
- Master 0 is the CPU load/store port; master 1 is the peripheral/loader DMA port.
- Serialises accesses into fixed 3-cycle transactions with round-robin fairness.
- Rejects peripheral-region (addr[31:28]==4'h4) and misaligned addresses with an error response; no memory strobe is issued for them.

Parameters:
- ADDR_W, 32, address width of both masters and the memory.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- m0_req  in  1  master 0 request; held with fields stable until m0_ack.
- m0_we  in  1  master 0: 1=write, 0=read.
- m0_addr  in  ADDR_W  master 0 byte address, word-aligned.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_ack  out  1  one-cycle completion pulse to master 0.
- m0_err  out  1  valid with m0_ack; access rejected.
- m0_rdata  out  DATA_W  master 0 read result, registered.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as master 0, for master 1.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe; memory writes on the clk edge.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr/mem_rd.
- busy  out  1  high in ACCESS or DONE.

Behaviour:
- Reset: state=IDLE, last_grant=1 (so master 0 wins the first tie), all latches 0, m*_rdata=0. Outputs: m*_ack=0, m*_err=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, busy=0.
- Reset asserted mid-transaction aborts it immediately: strobes drop asynchronously, no ack is issued, and the master must re-request.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - req is sampled on the clk edge.
  - If only one master requests, it is granted.
  - If both request, the master != last_grant is granted.
  - On grant: latch gnt, we, addr, wdata; err_l = (addr[31:28]==4'h4) | (addr[1:0]!=0); go to ACCESS.
  - No request: stay in IDLE.
- ACCESS (1 cycle):
  - mem_addr/mem_wdata driven from the latches.
  - mem_rd = ~we_l & ~err_l; mem_wr = we_l & ~err_l.
  - On the closing edge: the memory commits the write; the granted master's rdata <= (read & ~err) ? mem_rdata : 0; last_grant <= gnt; go to DONE.
- DONE (1 cycle):
  - mem_rd=mem_wr=0.
  - m{gnt}_ack=1 and m{gnt}_err=err_l; the other master's ack/err stay 0.
  - req is ignored this cycle; go to IDLE.
- Latency: req sampled at edge N, ack visible in cycle N+2. Maximum throughput is one transaction per 3 cycles.
- A master keeping req high after ack presents a new transaction; it is sampled in the following IDLE cycle. Round-robin then favours the other master if it is requesting.
- A request dropped before grant is simply lost; no ack is issued.
- Request changes during ACCESS/DONE have no effect: latched values are used.
- m*_rdata holds its value between that master's completions.
- Non-granted master's rdata is never modified.
- mem_addr/mem_wdata keep their latched values outside ACCESS; only the strobes gate the access.
- Starvation bound: a continuously requesting master waits at most one other transaction (≤6 cycles to ack).

Test Plan:
- Reset, then m0 write addr=0x10 data=0xDEADBEEF -> one mem_wr cycle with addr 0x10; m0_ack pulse 2 cycles after sample, err=0. Then m0 read 0x10 -> m0_rdata=0xDEADBEEF with ack, mem_rd high for exactly 1 cycle.
- m0 and m1 request in the same IDLE cycle (both reads) -> m0 served first, then m1. With both held continuously, grants alternate m0,m1,m0,m1; ack spacing is 3 cycles.
- m1 write to 0x40000004 -> no mem_wr/mem_rd at any time; m1_ack with m1_err=1; m1_rdata=0. Repeat with misaligned 0x00000006 -> same.
- m1 read 0x20 completes while m0_rdata holds 0x12345678 -> m0_rdata unchanged, m1_rdata updated.
- Assert reset during ACCESS of an m0 write -> strobes drop immediately, no m0_ack. After release, all outputs are 0 and a new request is served normally.
- m0 drops req one cycle before an IDLE sample -> no grant, state stays IDLE, busy=0.
